// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller.
// State encoding, counter width and AD-select phase codes.
package rtc_pkg;

   localparam int CNT_W = 8;

   localparam logic AD_SEL_ADDR = 1'b0;
   localparam logic AD_SEL_DATA = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      A_SETUP,
      A_STB,
      A_HOLD,
      D_SETUP,
      D_STB,
      D_HOLD,
      DONE
   } state_t;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase.
// zero is high once the counter has run out.
module rtc_phase_timer
   import rtc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Sequences one read or write transaction on the RTC multiplexed AD bus.
// Outputs are registered from the next-state decode.
module rtc_bus_ctrl
   import rtc_pkg::*;
#(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 4,
   parameter int T_HOLD  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_wr,
   input  logic       start_rd,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] ad_out,
   input  logic [7:0] ad_in,
   output logic       ad_oe,
   output logic       ad_sel,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n
);

   state_t state, state_nx;

   logic             op_wr;
   logic [7:0]       lat_addr;
   logic [7:0]       lat_wdata;
   logic             start;
   logic             ld;
   logic [CNT_W-1:0] ld_val;
   logic             zero;

   logic             nx_cs_n;
   logic             nx_wr_n;
   logic             nx_rd_n;
   logic             nx_oe;
   logic             nx_sel;
   logic [7:0]       nx_ad;
   logic             cur_wr;
   logic [7:0]       cur_addr;

   assign start = start_wr | start_rd;

   function automatic logic [CNT_W-1:0] dur(input state_t s);
      case (s)
         A_SETUP, D_SETUP: dur = CNT_W'(T_SETUP - 1);
         A_STB,   D_STB:   dur = CNT_W'(T_PULSE - 1);
         A_HOLD,  D_HOLD:  dur = CNT_W'(T_HOLD - 1);
         default:          dur = '0;
      endcase
   endfunction

   rtc_phase_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .zero     (zero)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = A_SETUP;
         A_SETUP: if (zero)  state_nx = A_STB;
         A_STB:   if (zero)  state_nx = A_HOLD;
         A_HOLD:  if (zero)  state_nx = D_SETUP;
         D_SETUP: if (zero)  state_nx = D_STB;
         D_STB:   if (zero)  state_nx = D_HOLD;
         D_HOLD:  if (zero)  state_nx = DONE;
         DONE:               state_nx = IDLE;
         default:            state_nx = IDLE;
      endcase
      ld     = (state_nx != state);
      ld_val = dur(state_nx);
   end

   // Operands are latched on the accepting edge, so use the live inputs then
   assign cur_wr   = (state == IDLE) ? start_wr : op_wr;
   assign cur_addr = (state == IDLE) ? addr     : lat_addr;

   always_comb begin
      nx_cs_n = 1'b1;
      nx_wr_n = 1'b1;
      nx_rd_n = 1'b1;
      nx_oe   = 1'b0;
      nx_sel  = AD_SEL_ADDR;
      nx_ad   = ad_out;
      unique case (state_nx)
         A_SETUP, A_STB, A_HOLD: begin
            nx_cs_n = 1'b0;
            nx_oe   = 1'b1;
            nx_ad   = cur_addr;
            nx_wr_n = (state_nx != A_STB);
         end
         D_SETUP, D_STB, D_HOLD: begin
            nx_cs_n = 1'b0;
            nx_sel  = AD_SEL_DATA;
            nx_oe   = cur_wr;
            if (cur_wr)
               nx_ad = lat_wdata;
            if (state_nx == D_STB) begin
               nx_wr_n = ~cur_wr;
               nx_rd_n = cur_wr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_wr     <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ad_out    <= '0;
         ad_oe     <= 1'b0;
         ad_sel    <= AD_SEL_ADDR;
         cs_n      <= 1'b1;
         wr_n      <= 1'b1;
         rd_n      <= 1'b1;
      end else begin
         state  <= state_nx;
         busy   <= (state_nx != IDLE);
         done   <= (state_nx == DONE);
         ad_out <= nx_ad;
         ad_oe  <= nx_oe;
         ad_sel <= nx_sel;
         cs_n   <= nx_cs_n;
         wr_n   <= nx_wr_n;
         rd_n   <= nx_rd_n;
         if (state == IDLE && start) begin
            op_wr     <= start_wr;
            lat_addr  <= addr;
            lat_wdata <= wdata;
         end
         if (state == D_STB && zero && !op_wr)
            rdata <= ad_in;
      end
   end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: per-transaction bus activity is
// tallied by a monitor and compared against queued expectations.
module tb_rtc_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_wr = 1'b0;
   logic       start_rd = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       busy;
   logic       done;
   logic [7:0] ad_out;
   logic [7:0] ad_in;
   logic       ad_oe;
   logic       ad_sel;
   logic       cs_n;
   logic       wr_n;
   logic       rd_n;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [7:0] last_rd = 8'h00;
   int         nvec = 0;
   int         nerr = 0;

   int         n_busy = 0, done_at = 0, n_done = 0;
   int         wa_cnt = 0, wd_cnt = 0, rd_cnt = 0;
   int         doe_cnt = 0, cs_hi = 0, both = 0;
   logic [7:0] wa_val = 8'h00, wd_val = 8'h00;

   always #5 clk = ~clk;

   assign ad_in = rd_n ? 8'h00 : 8'hA7;

   rtc_bus_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start_wr (start_wr),
      .start_rd (start_rd),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .ad_out   (ad_out),
      .ad_in    (ad_in),
      .ad_oe    (ad_oe),
      .ad_sel   (ad_sel),
      .cs_n     (cs_n),
      .wr_n     (wr_n),
      .rd_n     (rd_n)
   );

   always @(negedge clk) begin
      if ((start_wr || start_rd) && !busy) begin
         n_busy  <= 0;
         done_at <= 0;
         n_done  <= 0;
         wa_cnt  <= 0;
         wd_cnt  <= 0;
         rd_cnt  <= 0;
         doe_cnt <= 0;
         cs_hi   <= 0;
         both    <= 0;
      end else begin
         if (done) begin
            n_done  <= n_done + 1;
            done_at <= n_busy + 1;
         end
         if (busy) begin
            n_busy <= n_busy + 1;
            if (!wr_n && !ad_sel) begin
               wa_cnt <= wa_cnt + 1;
               wa_val <= ad_out;
            end
            if (!wr_n && ad_sel) begin
               wd_cnt <= wd_cnt + 1;
               wd_val <= ad_out;
            end
            if (!rd_n)          rd_cnt  <= rd_cnt + 1;
            if (ad_oe && ad_sel) doe_cnt <= doe_cnt + 1;
            if (cs_n)           cs_hi   <= cs_hi + 1;
            if (!wr_n && !rd_n) both    <= both + 1;
         end
      end
   end

   task automatic issue(input bit w, input bit r,
                        input logic [7:0] a, input logic [7:0] d);
      exp_t x;
      @(posedge clk);
      #1;
      start_wr = w;
      start_rd = r;
      addr     = a;
      wdata    = d;
      @(posedge clk);
      #1;
      start_wr = 1'b0;
      start_rd = 1'b0;
      addr     = 8'($urandom);
      wdata    = 8'($urandom);
      if (!w)
         last_rd = 8'hA7;
      x.wr    = w;
      x.addr  = a;
      x.wdata = d;
      x.rdata = last_rd;
      sb.push_back(x);
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      nvec++;
      if ({cs_n, wr_n, rd_n} !== 3'b111) begin
         nerr++;
         $display("FAIL reset_strobes got=%b want=111", {cs_n, wr_n, rd_n});
      end
      nvec++;
      if ({ad_oe, busy, done, ad_sel} !== 4'b0000) begin
         nerr++;
         $display("FAIL reset_ctl got=%b want=0000",
                  {ad_oe, busy, done, ad_sel});
      end
      nvec++;
      if (rdata !== 8'h00 || ad_out !== 8'h00) begin
         nerr++;
         $display("FAIL reset_data rdata=%h ad_out=%h want=00", rdata, ad_out);
      end
   endtask

   task automatic test_write;
      issue(1'b1, 1'b0, 8'h21, 8'h59);
      repeat (20) @(posedge clk);
      #1;
      nvec++;
      if (sb.size() == 0) begin
         nerr++;
         $display("FAIL wr_sb got=empty want=entry");
         return;
      end
      e = sb.pop_front();
      nvec++;
      if (n_busy !== 17 || done_at !== 17 || n_done !== 1) begin
         nerr++;
         $display("FAIL wr_timing busy=%0d done_at=%0d ndone=%0d want=17/17/1",
                  n_busy, done_at, n_done);
      end
      nvec++;
      if (wa_cnt !== 4 || wa_val !== e.addr) begin
         nerr++;
         $display("FAIL wr_addr_phase cnt=%0d val=%h want=4/%h",
                  wa_cnt, wa_val, e.addr);
      end
      nvec++;
      if (wd_cnt !== 4 || wd_val !== e.wdata) begin
         nerr++;
         $display("FAIL wr_data_phase cnt=%0d val=%h want=4/%h",
                  wd_cnt, wd_val, e.wdata);
      end
      nvec++;
      if (rd_cnt !== 0 || doe_cnt !== 8 || cs_hi !== 1 || both !== 0) begin
         nerr++;
         $display("FAIL wr_bus rd=%0d doe=%0d cshi=%0d both=%0d want=0/8/1/0",
                  rd_cnt, doe_cnt, cs_hi, both);
      end
      nvec++;
      if (rdata !== e.rdata || busy !== 1'b0) begin
         nerr++;
         $display("FAIL wr_end rdata=%h busy=%b want=%h/0",
                  rdata, busy, e.rdata);
      end
   endtask

   task automatic test_read;
      issue(1'b0, 1'b1, 8'h04, 8'hEE);
      repeat (20) @(posedge clk);
      #1;
      nvec++;
      if (sb.size() == 0) begin
         nerr++;
         $display("FAIL rd_sb got=empty want=entry");
         return;
      end
      e = sb.pop_front();
      nvec++;
      if (wa_cnt !== 4 || wa_val !== e.addr) begin
         nerr++;
         $display("FAIL rd_addr_phase cnt=%0d val=%h want=4/%h",
                  wa_cnt, wa_val, e.addr);
      end
      nvec++;
      if (wd_cnt !== 0 || rd_cnt !== 4 || doe_cnt !== 0) begin
         nerr++;
         $display("FAIL rd_data_phase wr=%0d rd=%0d doe=%0d want=0/4/0",
                  wd_cnt, rd_cnt, doe_cnt);
      end
      nvec++;
      if (rdata !== e.rdata || n_done !== 1 || n_busy !== 17) begin
         nerr++;
         $display("FAIL rd_result rdata=%h ndone=%0d busy=%0d want=%h/1/17",
                  rdata, n_done, n_busy, e.rdata);
      end
   endtask

   task automatic test_simultaneous;
      issue(1'b1, 1'b1, 8'h10, 8'h6C);
      repeat (20) @(posedge clk);
      #1;
      e = sb.pop_front();
      nvec++;
      if (rd_cnt !== 0 || wd_cnt !== 4 || wd_val !== e.wdata) begin
         nerr++;
         $display("FAIL both_start rd=%0d wd=%0d val=%h want=0/4/%h",
                  rd_cnt, wd_cnt, wd_val, e.wdata);
      end
      nvec++;
      if (wa_val !== e.addr || n_done !== 1 || rdata !== e.rdata) begin
         nerr++;
         $display("FAIL both_start_end addr=%h ndone=%0d rdata=%h want=%h/1/%h",
                  wa_val, n_done, rdata, e.addr, e.rdata);
      end
   endtask

   task automatic test_busy_ignore;
      issue(1'b1, 1'b0, 8'h45, 8'h9A);
      repeat (3) @(posedge clk);
      #1 start_rd = 1'b1;
      @(posedge clk);
      #1 start_rd = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      e = sb.pop_front();
      nvec++;
      if (n_done !== 1 || n_busy !== 17 || rd_cnt !== 0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL busy_ignore ndone=%0d busy=%0d rd=%0d now=%b want=1/17/0/0",
                  n_done, n_busy, rd_cnt, busy);
      end
      nvec++;
      if (wd_val !== e.wdata || sb.size() !== 0) begin
         nerr++;
         $display("FAIL busy_ignore_sb val=%h left=%0d want=%h/0",
                  wd_val, sb.size(), e.wdata);
      end
   endtask

   task automatic test_reset_abort;
      issue(1'b1, 1'b0, 8'h33, 8'hC4);
      void'(sb.pop_front());
      repeat (11) @(posedge clk);
      #1;
      nvec++;
      if (wr_n !== 1'b0 || ad_sel !== 1'b1) begin
         nerr++;
         $display("FAIL abort_in_dstb wr_n=%b sel=%b want=0/1", wr_n, ad_sel);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_rd = 8'h00;
      nvec++;
      if ({cs_n, wr_n, rd_n, ad_oe, busy, done} !== 6'b111000) begin
         nerr++;
         $display("FAIL abort_outputs got=%b want=111000",
                  {cs_n, wr_n, rd_n, ad_oe, busy, done});
      end
      nvec++;
      if (rdata !== 8'h00) begin
         nerr++;
         $display("FAIL abort_rdata got=%h want=00", rdata);
      end
      repeat (20) @(posedge clk);
      #1;
      nvec++;
      if (n_done !== 0) begin
         nerr++;
         $display("FAIL abort_no_done got=%0d want=0", n_done);
      end
      issue(1'b1, 1'b0, 8'h0B, 8'h3E);
      repeat (20) @(posedge clk);
      #1;
      e = sb.pop_front();
      nvec++;
      if (n_busy !== 17 || n_done !== 1 || wa_val !== e.addr ||
          wd_val !== e.wdata) begin
         nerr++;
         $display("FAIL after_abort busy=%0d ndone=%0d a=%h d=%h want=17/1/%h/%h",
                  n_busy, n_done, wa_val, wd_val, e.addr, e.wdata);
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_simultaneous;
      test_busy_ignore;
      test_reset_abort;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
